bias_slew_dac: RTL and testbench
================================

BIAS_SLEW_DAC -- requirements
Module: bias_slew_dac

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'd16, the GPIO address of register 0.
REQ-002 SHALL have parameter N_LANES, default 8, the number of 16-bit DAC lanes per clk.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gpio_in  input  32  [15:0] addr, [23:16] data byte, [24] w_clk strobe, [31:25] ignored.
REQ-006 SHALL have port setpt_in  input  16  signed lockbox setpoint; connects to the dynamic-lock setpt_out_ext.
REQ-007 SHALL have port lock_done_in  input  1  lockbox idle flag; target is sampled only while it is 1.
REQ-008 SHALL have port dac_data_out  output  16*N_LANES  the current bias value replicated on every lane.
REQ-009 SHALL have port at_target  output  1  high when the current bias equals the target.
REQ-010 SHALL have port enabled  output  1  mirror of CTRL[0].

Function
REQ-011 SHALL synchronise gpio_in[24] through 2 flops and act on its rising edge only.
REQ-012 SHALL, on that edge, when addr is BASE_ADDR+k (k=0..3), shift the byte into register k: reg_k <= {reg_k[7:0], data}, so 2-byte writes are MSB-first.
REQ-013 SHALL ignore writes to any other address.
REQ-014 SHALL use these 16-bit registers: 0 STEP (max slew per update, unsigned), 1 PERIOD (cycles between updates minus 1), 2 CTRL ([0] enable, [1] manual select), 3 MANUAL (signed manual target).
REQ-015 SHALL set target <= MANUAL when CTRL[1]=1; otherwise it SHALL set target <= setpt_in on cycles where lock_done_in=1, and hold target otherwise.
REQ-016 SHALL implement FSM states DISABLED, SETTLED and SLEW.
REQ-017 SHALL go from DISABLED to SLEW when CTRL[0]=1, and from any state to DISABLED when CTRL[0]=0.
REQ-018 SHALL, while DISABLED, hold cur at 0 and the period counter at 0.
REQ-019 SHALL move from SETTLED to SLEW when target != cur, and from SLEW to SETTLED when cur = target after an update.
REQ-020 SHALL run the period counter only in SLEW, counting 0..PERIOD; an update fires on the cycle where counter = PERIOD, and the counter then wraps to 0.
REQ-021 SHALL, with PERIOD=0, update every cycle.
REQ-022 SHALL compute each update as a 17-bit signed diff = target - cur, then cur <= cur + sign(diff)*min(|diff|, STEP).
REQ-023 SHALL treat STEP=0 as unlimited: cur <= target at the update.
REQ-024 SHALL keep the 16-bit signed result in range with no wrap; full-scale moves from -32768 to 32767 must be exact.
REQ-025 SHALL apply a target change in mid-slew at the next update, without restarting the period counter.
REQ-026 SHALL register dac_data_out so it equals cur replicated N_LANES times, one cycle after cur changes.
REQ-027 SHALL compute at_target combinationally as (cur == target) && enabled.
REQ-028 SHALL, on a GPIO write to STEP/PERIOD during SLEW, use the new value from the cycle after the write.

Reset
REQ-029 SHALL set the following on rst=1: state DISABLED; cur, target, counter, STEP, PERIOD, CTRL and MANUAL all 0; dac_data_out 0; at_target 0; sync flops 0.
REQ-030 SHALL, on reset during SLEW, output 0 on dac_data_out the cycle after rst is sampled.

Structure
REQ-031 SHALL take the following from package ising_config: the register offset constants (BS_STEP=0, BS_PERIOD=1, BS_CTRL=2, BS_MANUAL=3), the FSM state enum bs_state_t, and the DAC lane width constant.
REQ-032 SHALL implement the GPIO sync/edge/shift logic as the sub-module gpio_reg_bank (parameters BASE_ADDR and N_REGS=4), so other lock-chain blocks can reuse it.

Verification
REQ-033 SHALL test slew: STEP=100, PERIOD=3, enable, setpt_in=1000, lock_done_in=1 -> cur steps 100 every 4 cycles, reaches 1000 after 10 updates, then at_target=1 and state SETTLED.
REQ-034 SHALL test the partial last step: STEP=300, PERIOD=0, target -700 from 0 -> cur sequence -300, -600, -700 on consecutive cycles.
REQ-035 SHALL test manual plus gating: CTRL=3, MANUAL=-32768, STEP=0 -> cur=-32768 at the first update; changing setpt_in with lock_done_in=0 while CTRL[1]=0 -> target unchanged.
REQ-036 SHALL test full-scale: target 32767 from -32768 with STEP=65535 -> cur=32767 in one update, with no overflow.
REQ-037 SHALL test mid-slew reset: rst=1 for 1 cycle at cur=500 -> dac_data_out all-zero next cycle, all registers 0, enabled=0.
REQ-038 SHALL test the GPIO filter: write address BASE_ADDR+4 -> no register changes; holding w_clk high for 5 cycles -> exactly one byte shifted.

Source files
------------

// File: rtl/ising_config.sv
// ising_config: shared constants and types for the lock-chain blocks.
// Holds the bias slew DAC register offsets, its FSM state type, the
// DAC lane width, and the slew arithmetic helper used by bias_slew_dac.
package ising_config;

  // Width of one DAC lane sample
  localparam int DAC_LANE_W = 16;

  // Bias slew DAC register map, as offsets from the block's base address
  localparam int BS_N_REGS  = 4;
  localparam int BS_STEP    = 0;
  localparam int BS_PERIOD  = 1;
  localparam int BS_CTRL    = 2;
  localparam int BS_MANUAL  = 3;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    SETTLED  = 2'd1,
    SLEW     = 2'd2
  } bs_state_t;

  // One slew update: move cur towards target by at most step.
  // step == 0 means no limit. The difference is formed in 17 bits so a
  // full-scale move (-32768 -> 32767) cannot wrap; whenever the step is
  // smaller than the distance, cur +/- step lies strictly between cur and
  // target and therefore stays inside the 16-bit signed range.
  function automatic logic signed [15:0] slew_next(
    input logic signed [15:0] cur,
    input logic signed [15:0] target,
    input logic        [15:0] step
  );
    logic signed [16:0] diff;
    logic        [16:0] mag;
    logic        [16:0] moved;
    diff = {target[15], target} - {cur[15], cur};
    mag  = diff[16] ? 17'(-diff) : 17'(diff);
    if ((step == 16'd0) || (mag <= {1'b0, step})) begin
      slew_next = target;
    end else begin
      if (diff[16]) begin
        moved = {cur[15], cur} - {1'b0, step};
      end else begin
        moved = {cur[15], cur} + {1'b0, step};
      end
      slew_next = moved[15:0];
    end
  endfunction

endpackage

// File: rtl/gpio_reg_bank.sv
// gpio_reg_bank: byte-serial GPIO register bank shared by lock-chain blocks.
// The write strobe is brought into the clk domain through two flops and
// only its rising edge performs a write. A write to BASE_ADDR+k shifts the
// data byte into the low end of register k, so 16-bit values go MSB first.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   gpio_in  - [15:0] addr, [23:16] data byte, [24] write strobe
//   regs     - N_REGS packed 16-bit registers, register k at [16k +: 16]
module gpio_reg_bank #(
  parameter logic [15:0] BASE_ADDR = 16'd16,
  parameter int          N_REGS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           gpio_in,
  output logic [16*N_REGS-1:0]  regs
);

  logic        strobe_s0;
  logic        strobe_s1;
  logic        strobe_prev;
  logic        wr_edge;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        unused_bits;

  assign addr        = gpio_in[15:0];
  assign data        = gpio_in[23:16];
  assign unused_bits = ^gpio_in[31:25];

  // Strobe synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_s0   <= 1'b0;
      strobe_s1   <= 1'b0;
      strobe_prev <= 1'b0;
    end else begin
      strobe_s0   <= gpio_in[24];
      strobe_s1   <= strobe_s0;
      strobe_prev <= strobe_s1;
    end
  end

  // A strobe held high for many cycles still produces a single write
  assign wr_edge = strobe_s1 & ~strobe_prev;

  // Address and data are expected to be stable around the strobe, so they
  // are sampled directly when the synchronised edge arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_edge) begin
      for (int k = 0; k < N_REGS; k++) begin
        if (addr == BASE_ADDR + 16'(k)) begin
          regs[k*16 +: 16] <= {regs[k*16 +: 8], data};
        end
      end
    end
  end

endmodule

// File: rtl/bias_slew_dac.sv
// bias_slew_dac: slew-rate-limited bias output for the DAC lanes.
// The bias (cur) follows a target taken either from the lockbox setpoint
// (sampled only while the lockbox is idle) or from a manual register, moving
// at most STEP counts every PERIOD+1 cycles.
// Ports:
//   clk           - rising-edge clock
//   rst           - synchronous active-high reset
//   gpio_in       - byte-serial register write bus (see gpio_reg_bank)
//   setpt_in      - signed lockbox setpoint
//   lock_done_in  - lockbox idle; setpoint is sampled only while high
//   dac_data_out  - registered cur replicated on all N_LANES lanes
//   at_target     - cur equals target and the block is enabled
//   enabled       - CTRL[0]
module bias_slew_dac
  import ising_config::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'd16,
  parameter int          N_LANES   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    gpio_in,
  input  logic signed [15:0]             setpt_in,
  input  logic                           lock_done_in,
  output logic [DAC_LANE_W*N_LANES-1:0]  dac_data_out,
  output logic                           at_target,
  output logic                           enabled
);

  logic [16*BS_N_REGS-1:0] bank_regs;
  logic [15:0]             step;
  logic [15:0]             period;
  logic [15:0]             ctrl;
  logic signed [15:0]      manual;
  logic                    unused_ctrl;

  logic signed [15:0]      target_q;
  logic signed [15:0]      cur_q;
  logic signed [15:0]      cur_d;
  logic signed [15:0]      slew_val;
  logic [15:0]             cnt_q;
  logic [15:0]             cnt_d;
  bs_state_t               state_q;
  bs_state_t               state_d;

  gpio_reg_bank #(
    .BASE_ADDR (BASE_ADDR),
    .N_REGS    (BS_N_REGS)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .regs    (bank_regs)
  );

  assign step        = bank_regs[BS_STEP*16   +: 16];
  assign period      = bank_regs[BS_PERIOD*16 +: 16];
  assign ctrl        = bank_regs[BS_CTRL*16   +: 16];
  assign manual      = bank_regs[BS_MANUAL*16 +: 16];
  assign unused_ctrl = ^ctrl[15:2];

  assign enabled   = ctrl[0];
  assign at_target = (cur_q == target_q) && ctrl[0];

  // Target selection: manual overrides; otherwise the lockbox setpoint is
  // only trusted while the lockbox reports idle
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
    end else if (ctrl[1]) begin
      target_q <= manual;
    end else if (lock_done_in) begin
      target_q <= setpt_in;
    end
  end

  assign slew_val = slew_next(cur_q, target_q, step);

  // Next-state logic. The compare uses >= so that shrinking PERIOD below
  // the running count mid-slew fires at once instead of waiting for the
  // 16-bit counter to wrap.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      DISABLED: begin
        cur_d = '0;
        cnt_d = '0;
        if (ctrl[0]) begin
          state_d = SLEW;
        end
      end
      SETTLED: begin
        cnt_d = '0;
        if (target_q != cur_q) begin
          state_d = SLEW;
        end
      end
      SLEW: begin
        if (cnt_q >= period) begin
          cur_d = slew_val;
          cnt_d = '0;
          if (slew_val == target_q) begin
            state_d = SETTLED;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = DISABLED;
        cur_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (!ctrl[0]) begin
      state_d = DISABLED;
      cur_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISABLED;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: lanes lag cur by exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data_out <= '0;
    end else begin
      dac_data_out <= {N_LANES{cur_q}};
    end
  end

endmodule

// File: tb/tb_bias_slew_dac.sv
// tb_bias_slew_dac: self-checking bench for bias_slew_dac.
// Drives registers over the byte-serial GPIO bus, records every change of
// lane 0 and compares the recorded trajectory against an arithmetic model.
module tb_bias_slew_dac;
  import ising_config::*;

  localparam logic [15:0] BASE  = 16'd16;
  localparam int          LANES = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [31:0]              gpio_in;
  logic signed [15:0]       setpt_in;
  logic                     lock_done_in;
  logic [16*LANES-1:0]      dac_data_out;
  logic                     at_target;
  logic                     enabled;

  int total = 0;
  int bad   = 0;
  int seen_val[$];
  int seen_cyc[$];
  int exp_val[$];

  typedef struct {
    int step;
    int period;
    int target;
    int n_upd;
    int first;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  bias_slew_dac #(
    .BASE_ADDR (BASE),
    .N_LANES   (LANES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .setpt_in     (setpt_in),
    .lock_done_in (lock_done_in),
    .dac_data_out (dac_data_out),
    .at_target    (at_target),
    .enabled      (enabled)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane0();
    return int'($signed(dac_data_out[15:0]));
  endfunction

  function automatic int lanesEqual();
    for (int i = 1; i < LANES; i++) begin
      if (dac_data_out[i*16 +: 16] != dac_data_out[15:0]) return 0;
    end
    return 1;
  endfunction

  // One GPIO byte write: strobe high for 'hold' cycles, then idle 'settle'
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                               input int hold, input int settle);
    @(negedge clk);
    gpio_in = {7'd0, 1'b1, data, addr};
    repeat (hold) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic writeReg(input int k, input logic [15:0] val, input int last_settle);
    applyStimulus(BASE + 16'(k), val[15:8], 1, 3);
    applyStimulus(BASE + 16'(k), val[7:0], 1, last_settle);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    gpio_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Record each change of lane 0 with the cycle it appeared on
  task automatic watch(input int n);
    int prev;
    int v;
    seen_val.delete();
    seen_cyc.delete();
    prev = lane0();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v = lane0();
      if (v != prev) begin
        seen_val.push_back(v);
        seen_cyc.push_back(i);
      end
      prev = v;
    end
  endtask

  // Reference trajectory: repeatedly close the gap by at most step
  task automatic model(input int start, input int step, input int tgt);
    int cur;
    int d;
    exp_val.delete();
    cur = start;
    while (cur != tgt) begin
      d = tgt - cur;
      if (step == 0 || (d < 0 ? -d : d) <= step) cur = tgt;
      else cur = cur + (d > 0 ? step : -step);
      exp_val.push_back(cur);
    end
  endtask

  task automatic compareTrajectory(input string name, input int period);
    int mism;
    int bad_int;
    mism = 0;
    bad_int = 0;
    checkOutput({name, "_len"}, seen_val.size(), exp_val.size());
    for (int i = 0; i < seen_val.size() && i < exp_val.size(); i++) begin
      if (seen_val[i] != exp_val[i]) mism++;
    end
    checkOutput({name, "_seq"}, mism, 0);
    for (int i = 1; i < seen_cyc.size(); i++) begin
      if (seen_cyc[i] - seen_cyc[i-1] != period + 1) bad_int++;
    end
    checkOutput({name, "_interval"}, bad_int, 0);
  endtask

  // Fresh reset, configure, enable from setpoint, record the slew
  task automatic runCase(input int step, input int period, input int target, input int budget);
    pulseReset();
    setpt_in = 16'(target);
    lock_done_in = 1'b1;
    writeReg(BS_STEP, 16'(step), 3);
    writeReg(BS_PERIOD, 16'(period), 3);
    writeReg(BS_CTRL, 16'h0001, 0);
    watch(budget);
  endtask

  initial begin
    int guard;
    int tgt;
    int stp;
    int per;
    logic [15:0] r16;

    rst = 1'b1;
    gpio_in = '0;
    setpt_in = '0;
    lock_done_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    pulseReset();
    checkOutput("rst_dac", lane0(), 0);
    checkOutput("rst_at_target", int'(at_target), 0);
    checkOutput("rst_enabled", int'(enabled), 0);
    checkOutput("rst_state", int'(dut.state_q), int'(DISABLED));

    // Table-driven slews from 0
    vecs[0] = '{100, 3, 1000, 10, 100};
    vecs[1] = '{300, 0, -700, 3, -300};
    vecs[2] = '{0, 2, -32768, 1, -32768};
    vecs[3] = '{65535, 1, 32767, 1, 32767};
    vecs[4] = '{7, 0, 20, 3, 7};
    for (int v = 0; v < 5; v++) begin
      runCase(vecs[v].step, vecs[v].period, vecs[v].target,
              (vecs[v].period + 1) * vecs[v].n_upd + 12);
      model(0, vecs[v].step, vecs[v].target);
      checkOutput($sformatf("vec%0d_updates", v), seen_val.size(), vecs[v].n_upd);
      checkOutput($sformatf("vec%0d_first", v), seen_val.size() > 0 ? seen_val[0] : 0, vecs[v].first);
      checkOutput($sformatf("vec%0d_final", v), lane0(), vecs[v].target);
      compareTrajectory($sformatf("vec%0d", v), vecs[v].period);
      checkOutput($sformatf("vec%0d_at_target", v), int'(at_target), 1);
      checkOutput($sformatf("vec%0d_state", v), int'(dut.state_q), int'(SETTLED));
      checkOutput($sformatf("vec%0d_lanes", v), lanesEqual(), 1);
    end

    // Randomised slews against the model
    for (int r = 0; r < 6; r++) begin
      stp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2000, 65535));
      per = int'($urandom_range(0, 3));
      r16 = 16'($urandom_range(1, 65535));
      tgt = int'($signed(r16));
      model(0, stp, tgt);
      runCase(stp, per, tgt, (per + 1) * exp_val.size() + 12);
      compareTrajectory($sformatf("rand%0d", r), per);
      checkOutput($sformatf("rand%0d_at_target", r), int'(at_target), 1);
    end

    // Full scale: settle at -32768, then jump the setpoint to 32767
    runCase(65535, 1, -32768, 20);
    checkOutput("fs_start", lane0(), -32768);
    setpt_in = 16'sd32767;
    watch(20);
    checkOutput("fs_updates", seen_val.size(), 1);
    checkOutput("fs_value", lane0(), 32767);
    checkOutput("fs_at_target", int'(at_target), 1);

    // Manual target with unlimited step, then setpoint gating
    pulseReset();
    lock_done_in = 1'b0;
    setpt_in = 16'sd555;
    writeReg(BS_STEP, 16'h0000, 3);
    writeReg(BS_MANUAL, 16'h8000, 3);
    writeReg(BS_CTRL, 16'h0003, 0);
    watch(12);
    checkOutput("man_updates", seen_val.size(), 1);
    checkOutput("man_value", lane0(), -32768);
    checkOutput("man_at_target", int'(at_target), 1);
    writeReg(BS_CTRL, 16'h0001, 3);
    setpt_in = 16'sd1234;
    repeat (10) @(negedge clk);
    checkOutput("gate_target", int'(dut.target_q), -32768);
    checkOutput("gate_dac", lane0(), -32768);
    lock_done_in = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("ungate_dac", lane0(), 1234);

    // Mid-slew reset at cur=500
    runCase(100, 3, 1000, 0);
    guard = 0;
    while (lane0() != 500 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("mid_reach500", lane0(), 500);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_dac_zero", int'(dac_data_out == '0), 1);
    checkOutput("mid_enabled", int'(enabled), 0);
    checkOutput("mid_at_target", int'(at_target), 0);
    checkOutput("mid_regs_zero",
                int'(|{dut.step, dut.period, dut.ctrl, dut.manual, dut.target_q, dut.cur_q}), 0);
    checkOutput("mid_state", int'(dut.state_q), int'(DISABLED));
    rst = 1'b0;

    // GPIO filter: out-of-range address and a long strobe
    pulseReset();
    applyStimulus(BASE + 16'd4, 8'h5A, 1, 3);
    checkOutput("flt_no_write", int'(|{dut.step, dut.period, dut.ctrl, dut.manual}), 0);
    applyStimulus(BASE, 8'hAB, 5, 3);
    checkOutput("flt_one_shift", int'(dut.step), 32'h00AB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
